// File: rtl/median9_scheduler.sv
// Exact 3x3 median: one shared 3-input sorter runs the 7-op network (3 row sorts,
// 3 column selects, 1 final select), with results matched to issues by a tag pipeline.
module median9_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CMP_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [9*DATA_WIDTH-1:0] in_win,
  output logic [DATA_WIDTH-1:0]   cmp_a,
  output logic [DATA_WIDTH-1:0]   cmp_b,
  output logic [DATA_WIDTH-1:0]   cmp_c,
  output logic                    cmp_issue,
  input  logic [DATA_WIDTH-1:0]   cmp_max,
  input  logic [DATA_WIDTH-1:0]   cmp_mid,
  input  logic [DATA_WIDTH-1:0]   cmp_min,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_median,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE, ROW, WAIT_R, COL, WAIT_C, FIN, WAIT_F, DONE
  } state_e;

  typedef logic [DATA_WIDTH-1:0] pix_t;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       accept;
  logic [2:0] op;

  pix_t pix_q  [9];
  pix_t rmax_q [3];
  pix_t rmid_q [3];
  pix_t rmin_q [3];
  pix_t lo_of_hi_q, mid_of_mid_q, hi_of_lo_q;
  pix_t median_q;

  logic       tag_vld_q [CMP_LAT];
  logic [2:0] tag_op_q  [CMP_LAT];
  logic       res_vld;
  logic [2:0] res_op;

  assign res_vld    = tag_vld_q[CMP_LAT-1];
  assign res_op     = tag_op_q[CMP_LAT-1];
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_median = median_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmp_issue = 1'b0;
    op        = '0;
    cmp_a     = '0;
    cmp_b     = '0;
    cmp_c     = '0;
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept    = in_valid && in_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ROW;
          cnt_d   = '0;
        end
      end
      ROW: begin
        cmp_issue = 1'b1;
        op        = {1'b0, cnt_q};
        case (cnt_q)
          2'd0:    begin cmp_a = pix_q[0]; cmp_b = pix_q[1]; cmp_c = pix_q[2]; end
          2'd1:    begin cmp_a = pix_q[3]; cmp_b = pix_q[4]; cmp_c = pix_q[5]; end
          default: begin cmp_a = pix_q[6]; cmp_b = pix_q[7]; cmp_c = pix_q[8]; end
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          state_d = WAIT_R;
          cnt_d   = '0;
        end
      end
      WAIT_R: begin
        if (res_vld && res_op == 3'd2) state_d = COL;
      end
      COL: begin
        cmp_issue = 1'b1;
        op        = 3'd3 + {1'b0, cnt_q};
        case (cnt_q)
          2'd0:    begin cmp_a = rmax_q[0]; cmp_b = rmax_q[1]; cmp_c = rmax_q[2]; end
          2'd1:    begin cmp_a = rmid_q[0]; cmp_b = rmid_q[1]; cmp_c = rmid_q[2]; end
          default: begin cmp_a = rmin_q[0]; cmp_b = rmin_q[1]; cmp_c = rmin_q[2]; end
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          state_d = WAIT_C;
          cnt_d   = '0;
        end
      end
      WAIT_C: begin
        if (res_vld && res_op == 3'd5) state_d = FIN;
      end
      FIN: begin
        cmp_issue = 1'b1;
        op        = 3'd6;
        cmp_a     = lo_of_hi_q;
        cmp_b     = mid_of_mid_q;
        cmp_c     = hi_of_lo_q;
        state_d   = WAIT_F;
      end
      WAIT_F: begin
        if (res_vld && res_op == 3'd6) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          // Output handoff and next window accept share this cycle, so no bubble.
          if (accept) begin
            state_d = ROW;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      median_q <= '0;
      for (int unsigned i = 0; i < CMP_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_op_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_vld_q[0] <= cmp_issue;
      tag_op_q[0]  <= op;
      for (int unsigned i = 1; i < CMP_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_op_q[i]  <= tag_op_q[i-1];
      end
      if (res_vld && res_op == 3'd6) median_q <= cmp_mid;
    end
  end

  // Datapath storage needs no reset: every value is written before it is read.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < 9; i++) begin
        pix_q[i] <= in_win[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (res_vld) begin
      case (res_op)
        3'd0: begin rmax_q[0] <= cmp_max; rmid_q[0] <= cmp_mid; rmin_q[0] <= cmp_min; end
        3'd1: begin rmax_q[1] <= cmp_max; rmid_q[1] <= cmp_mid; rmin_q[1] <= cmp_min; end
        3'd2: begin rmax_q[2] <= cmp_max; rmid_q[2] <= cmp_mid; rmin_q[2] <= cmp_min; end
        3'd3: lo_of_hi_q   <= cmp_min;
        3'd4: mid_of_mid_q <= cmp_mid;
        3'd5: hi_of_lo_q   <= cmp_max;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_median9_scheduler.sv
// Bench for median9_scheduler: two instances (latency 1 and 3) each paired with a
// behavioural 3-input sorter; directed windows with hand-computed medians.
module tb_median9_scheduler;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, sel;
  logic [9*W-1:0] in_win;

  logic         ir1, iss1, ov1, busy1, ir3, iss3, ov3, busy3;
  logic [W-1:0] a1, b1, c1, mx1, md1, mn1, med1;
  logic [W-1:0] a3, b3, c3, mx3, md3, mn3, med3;

  median9_scheduler #(.DATA_WIDTH(W), .CMP_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir1), .in_win(in_win),
    .cmp_a(a1), .cmp_b(b1), .cmp_c(c1), .cmp_issue(iss1),
    .cmp_max(mx1), .cmp_mid(md1), .cmp_min(mn1),
    .out_valid(ov1), .out_ready(out_ready), .out_median(med1), .busy(busy1));

  median9_scheduler #(.DATA_WIDTH(W), .CMP_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir3), .in_win(in_win),
    .cmp_a(a3), .cmp_b(b3), .cmp_c(c3), .cmp_issue(iss3),
    .cmp_max(mx3), .cmp_mid(md3), .cmp_min(mn3),
    .out_valid(ov3), .out_ready(out_ready), .out_median(med3), .busy(busy3));

  function automatic logic [3*W-1:0] sort3(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    logic [W-1:0] hi, lo;
    hi = a; if (b > hi) hi = b; if (c > hi) hi = c;
    lo = a; if (b < lo) lo = b; if (c < lo) lo = c;
    return {hi, a ^ b ^ c ^ hi ^ lo, lo};
  endfunction

  logic [3*W-1:0] p1;
  logic [3*W-1:0] p3 [3];
  always @(posedge clk) begin
    p1    <= sort3(a1, b1, c1);
    p3[0] <= sort3(a3, b3, c3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {mx1, md1, mn1} = p1;
  assign {mx3, md3, mn3} = p3[2];

  logic         m_ir, m_iss, m_ov, m_busy;
  logic [W-1:0] m_a, m_b, m_c, m_med;
  assign m_ir   = sel ? ir3   : ir1;
  assign m_iss  = sel ? iss3  : iss1;
  assign m_ov   = sel ? ov3   : ov1;
  assign m_busy = sel ? busy3 : busy1;
  assign m_a    = sel ? a3    : a1;
  assign m_b    = sel ? b3    : b1;
  assign m_c    = sel ? c3    : c1;
  assign m_med  = sel ? med3  : med1;

  int vecs = 0;
  int errs = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [9*W-1:0] mkwin(
      input logic [W-1:0] p0, input logic [W-1:0] p1_, input logic [W-1:0] p2,
      input logic [W-1:0] p3_, input logic [W-1:0] p4, input logic [W-1:0] p5,
      input logic [W-1:0] p6, input logic [W-1:0] p7, input logic [W-1:0] p8);
    return {p8, p7, p6, p5, p4, p3_, p2, p1_, p0};
  endfunction

  typedef struct {
    logic [9*W-1:0] win;
    logic [W-1:0]   med;
  } vec_t;
  vec_t tbl [8];

  // One window with out_ready=1 on the selected instance; checks cycle-exact issue
  // pattern, out_valid timing and median.
  task automatic run_window(input logic [9*W-1:0] win, input logic [W-1:0] exp, input string nm);
    int L;
    logic [31:0]  iss_mask, ov_mask, exp_iss, exp_ov;
    logic [W-1:0] med;
    L = sel ? 3 : 1;
    exp_iss = '0;
    exp_iss[1] = 1'b1; exp_iss[2] = 1'b1; exp_iss[3] = 1'b1;
    exp_iss[4+L] = 1'b1; exp_iss[5+L] = 1'b1; exp_iss[6+L] = 1'b1;
    exp_iss[7+2*L] = 1'b1;
    exp_ov = '0;
    exp_ov[8+3*L] = 1'b1;
    iss_mask = '0; ov_mask = '0; med = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_win = win; in_valid = 1'b1;
    @(negedge clk);
    check($sformatf("%s/in_ready", nm), 32'(m_ir), 32'd1);
    for (int cy = 1; cy <= 10 + 3*L; cy++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_win = '1;
      @(negedge clk);
      if (m_iss) iss_mask[cy] = 1'b1;
      if (m_ov) begin ov_mask[cy] = 1'b1; med = m_med; end
      if (cy == 1) check($sformatf("%s/row0_ops", nm), 32'({m_a, m_b, m_c}),
                         32'({win[7:0], win[15:8], win[23:16]}));
      if (cy == 4) check($sformatf("%s/idle_ops", nm), 32'({m_a, m_b, m_c}), 32'd0);
    end
    check($sformatf("%s/issue_cycles", nm), iss_mask, exp_iss);
    check($sformatf("%s/out_valid_cycle", nm), ov_mask, exp_ov);
    check($sformatf("%s/median", nm), 32'(med), 32'(exp));
  endtask

  initial begin
    int acc_cnt, res_cnt, n;
    int acc_cyc [3];
    int out_cyc [3];
    logic acc_now, got;

    tbl[0] = '{mkwin(8'd9, 8'd1, 8'd5, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6), 8'd5};
    tbl[1] = '{mkwin(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA), 8'hAA};
    tbl[2] = '{mkwin(8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd128), 8'd128};
    tbl[3] = '{mkwin(8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1), 8'd5};
    tbl[4] = '{mkwin(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90), 8'd50};
    tbl[5] = '{mkwin(8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9, 8'd0), 8'd2};
    tbl[6] = '{mkwin(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 8'd0};
    tbl[7] = '{mkwin(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255), 8'd255};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; in_win = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset/ctl_l1", 32'({ir1, ov1, busy1, iss1}), 32'b1000);
    check("reset/data_l1", 32'({a1, b1, c1, med1}), 32'd0);
    check("reset/ctl_l3", 32'({ir3, ov3, busy3, iss3}), 32'b1000);
    check("reset/data_l3", 32'({a3, b3, c3, med3}), 32'd0);

    for (int i = 0; i < 8; i++) run_window(tbl[i].win, tbl[i].med, $sformatf("vec%0d", i));

    // Backpressure: hold the result for 5 cycles, then hand off and accept in one cycle.
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_win = tbl[0].win; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_win = '1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_ov) begin got = 1'b1; break; end
    end
    check("bp/out_valid_rise", 32'(got), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp/hold%0d", k), 32'({m_ov, m_ir, m_busy, m_med}), 32'({3'b101, 8'd5}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b1; in_win = tbl[1].win;
    @(negedge clk);
    check("bp/handoff", 32'({m_ov, m_ir}), 32'b11);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_win = '1;
      @(negedge clk);
      if (m_ov) begin n = i; break; end
    end
    check("bp/second_latency", 32'(n), 32'd11);
    check("bp/second_median", 32'(m_med), 32'hAA);

    // Back-to-back: in_valid held across three windows.
    acc_cnt = 0; res_cnt = 0;
    for (int i = 0; i < 3; i++) begin acc_cyc[i] = -1; out_cyc[i] = -1; end
    @(posedge clk); #1;
    in_valid = 1'b1; in_win = tbl[0].win;
    for (int cy = 0; cy < 40; cy++) begin
      @(negedge clk);
      if (m_ov) begin
        if (res_cnt < 3) begin
          check($sformatf("b2b/median%0d", res_cnt), 32'(m_med), 32'(tbl[res_cnt].med));
          out_cyc[res_cnt] = cy;
        end
        res_cnt++;
      end
      acc_now = in_valid && m_ir;
      if (acc_now) begin
        if (acc_cnt < 3) acc_cyc[acc_cnt] = cy;
        acc_cnt++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        if (acc_cnt < 3) in_win = tbl[acc_cnt].win;
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b/accepts", 32'(acc_cnt), 32'd3);
    check("b2b/results", 32'(res_cnt), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b/accept_cycle%0d", i), 32'(acc_cyc[i]), 32'(11*i));
      check($sformatf("b2b/out_cycle%0d", i), 32'(out_cyc[i]), 32'(11*i + 11));
    end

    // Reset during WAIT_C aborts the window.
    @(posedge clk); #1;
    in_win = tbl[0].win; in_valid = 1'b1;
    for (int cy = 1; cy <= 8; cy++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_win = '1;
    end
    @(negedge clk);
    check("rst/in_wait_c", 32'({m_busy, m_iss}), 32'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst/after", 32'({m_ir, m_ov, m_busy, m_iss}), 32'b1000);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ov || m_busy) got = 1'b1;
    end
    check("rst/no_stale_output", 32'(got), 32'd0);
    run_window(tbl[2].win, tbl[2].med, "rst/next");

    // Latency-3 instance.
    sel = 1'b1;
    run_window(tbl[0].win, tbl[0].med, "lat3/w0");
    run_window(tbl[5].win, tbl[5].med, "lat3/ties");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
